// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } state_e;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_e;

endpackage

// File: rtl/mem_arb_rr.sv
// Round-robin pick between fetch and data requesters; purely combinational.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic iReq,
    input  logic dReq,
    input  logic lastGrant,
    output logic grantI,
    output logic grantD
);

    always_comb begin
        grantI = iReq;
        grantD = dReq;
        // On a conflict the port that did not win last time goes first.
        if (iReq && dReq) begin
            grantI = (lastGrant == GRANT_D);
            grantD = (lastGrant == GRANT_I);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-cycle RAM between fetch and data ports; grant is combinational
// in IDLE, reads return data exactly one cycle later, writes complete in the grant cycle.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              iReq,
    input  logic [ADDR_W-1:0] iAddr,
    output logic              iReady,
    output logic              iRValid,
    output logic [DATA_W-1:0] iRData,
    input  logic              dReq,
    input  logic [ADDR_W-1:0] dAddr,
    input  logic [3:0]        dWMask,
    input  logic [DATA_W-1:0] dWData,
    output logic              dReady,
    output logic              dRValid,
    output logic [DATA_W-1:0] dRData,
    output logic [ADDR_W-1:0] ramAddr,
    output logic              ramRStrb,
    output logic [DATA_W-1:0] ramWData,
    output logic [3:0]        ramWMask,
    input  logic [DATA_W-1:0] ramRData,
    output logic [CNT_W-1:0]  conflictCount
);

    state_e           state_d, state_q;
    grant_e           last_d, last_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic             idle, grant_i, grant_d, d_read, conflict;

    // Reset masks every grant and response in the same cycle it is asserted.
    assign idle     = (state_q == IDLE) && !reset;
    assign d_read   = (dWMask == 4'b0000);
    assign conflict = idle && iReq && dReq;

    mem_arb_rr u_rr (
        .iReq      (iReq && idle),
        .dReq      (dReq && idle),
        .lastGrant (last_q),
        .grantI    (grant_i),
        .grantD    (grant_d)
    );

    assign iReady   = grant_i;
    assign dReady   = grant_d;
    assign ramAddr  = grant_d ? dAddr : iAddr;
    assign ramRStrb = grant_i || (grant_d && d_read);
    assign ramWMask = grant_d ? dWMask : 4'b0000;
    assign ramWData = dWData;

    assign iRValid = (state_q == WAIT_I) && !reset;
    assign dRValid = (state_q == WAIT_D) && !reset;
    assign iRData  = ramRData;
    assign dRData  = ramRData;
    assign conflictCount = cnt_q;

    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        cnt_d   = cnt_q;
        if (grant_i) begin
            state_d = WAIT_I;
            last_d  = GRANT_I;
        end else if (grant_d) begin
            // Writes finish in the grant cycle, leaving IDLE free for a back-to-back grant.
            state_d = d_read ? WAIT_D : IDLE;
            last_d  = GRANT_D;
        end
        if (conflict && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= GRANT_D;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter: stimulus queues expected grants/reads, monitor checks.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        iReq, dReq;
    logic [31:0] iAddr, dAddr, dWData;
    logic [3:0]  dWMask;
    logic        iReady, iRValid, dReady, dRValid, ramRStrb;
    logic [31:0] iRData, dRData, ramAddr, ramWData, ramRData;
    logic [3:0]  ramWMask;
    logic [15:0] conflictCount;

    logic        iReady_s, iRValid_s, dReady_s, dRValid_s, ramRStrb_s;
    logic [31:0] iRData_s, dRData_s, ramAddr_s, ramWData_s;
    logic [3:0]  ramWMask_s;
    logic [1:0]  conflictCount_s;

    logic [31:0] ram_addr_q;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc_n  = 0;
    int rv_due = -1;

    typedef struct {
        logic        is_d;
        logic [31:0] addr;
        logic        strb;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } gexp_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];

    always #5 clk = ~clk;

    mem_arbiter u_dut (
        .clk(clk), .reset(reset),
        .iReq(iReq), .iAddr(iAddr), .iReady(iReady), .iRValid(iRValid), .iRData(iRData),
        .dReq(dReq), .dAddr(dAddr), .dWMask(dWMask), .dWData(dWData),
        .dReady(dReady), .dRValid(dRValid), .dRData(dRData),
        .ramAddr(ramAddr), .ramRStrb(ramRStrb), .ramWData(ramWData), .ramWMask(ramWMask),
        .ramRData(ramRData), .conflictCount(conflictCount)
    );

    mem_arbiter #(.CNT_W(2)) u_dut_s (
        .clk(clk), .reset(reset),
        .iReq(iReq), .iAddr(iAddr), .iReady(iReady_s), .iRValid(iRValid_s), .iRData(iRData_s),
        .dReq(dReq), .dAddr(dAddr), .dWMask(dWMask), .dWData(dWData),
        .dReady(dReady_s), .dRValid(dRValid_s), .dRData(dRData_s),
        .ramAddr(ramAddr_s), .ramRStrb(ramRStrb_s), .ramWData(ramWData_s), .ramWMask(ramWMask_s),
        .ramRData(ramRData), .conflictCount(conflictCount_s)
    );

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return {~a[15:0], a[15:0]};
    endfunction

    // RAM model: data for the address presented last cycle.
    always @(posedge clk) ram_addr_q <= ramAddr;
    assign ramRData = mem_f(ram_addr_q);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc_n);
        end
    endtask

    task automatic exp_grant(input logic is_d, input logic [31:0] addr,
                             input logic [3:0] mask, input logic [31:0] wdata);
        gexp_t g;
        g.is_d = is_d; g.addr = addr; g.strb = (mask == 4'b0000);
        g.mask = mask; g.wdata = wdata;
        gq.push_back(g);
    endtask

    task automatic exp_read(input logic is_d, input logic [31:0] addr);
        rexp_t r;
        r.is_d = is_d; r.data = mem_f(addr);
        rq.push_back(r);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        gexp_t g;
        rexp_t r;
        cyc_n++;
        if (reset) begin
            chk("reset_outputs", {23'b0, iReady, dReady, ramRStrb, ramWMask, iRValid, dRValid}, 32'b0);
            rv_due = -1;
        end else begin
            if (iRValid || dRValid) begin
                if (rq.size() == 0) begin
                    chk("rvalid_expected", rq.size(), 1);
                end else begin
                    r = rq.pop_front();
                    chk("rvalid_port", dRValid, r.is_d);
                    chk("rvalid_onehot", iRValid & dRValid, 0);
                    chk("rdata", dRValid ? dRData : iRData, r.data);
                    chk("rd_latency", cyc_n, rv_due);
                end
                rv_due = -1;
            end else if (rv_due == cyc_n) begin
                chk("missing_rvalid", iRValid | dRValid, 1);
                rv_due = -1;
            end
            if (iReady || dReady) begin
                if (gq.size() == 0) begin
                    chk("grant_expected", gq.size(), 1);
                end else begin
                    g = gq.pop_front();
                    chk("grant_port", dReady, g.is_d);
                    chk("grant_onehot", iReady & dReady, 0);
                    chk("ram_addr", ramAddr, g.addr);
                    chk("ram_rstrb", ramRStrb, g.strb);
                    chk("ram_wmask", ramWMask, g.mask);
                    if (!g.strb) chk("ram_wdata", ramWData, g.wdata);
                    if (g.strb) rv_due = cyc_n + 1;
                end
            end else begin
                chk("idle_ram", {ramRStrb, ramWMask}, 5'b0);
            end
        end
    end

    initial begin
        reset = 1'b1; iReq = 1'b1; dReq = 1'b1;
        iAddr = 32'h100; dAddr = 32'h200; dWMask = 4'h0; dWData = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0; iReq = 1'b0; dReq = 1'b0;
        chk("cnt_after_reset", conflictCount, 0);
        chk("cnt_s_after_reset", conflictCount_s, 0);

        // Single fetch read
        iReq = 1'b1; iAddr = 32'h100;
        exp_grant(1'b0, 32'h100, 4'h0, 32'h0); exp_read(1'b0, 32'h100);
        cyc(); iReq = 1'b0;
        cyc(); cyc();

        // Data write followed immediately by a fetch grant
        dReq = 1'b1; dAddr = 32'h204; dWMask = 4'h3; dWData = 32'h0000_ABCD;
        exp_grant(1'b1, 32'h204, 4'h3, 32'h0000_ABCD);
        cyc(); dReq = 1'b0; dWMask = 4'h0;
        iReq = 1'b1; iAddr = 32'h108;
        exp_grant(1'b0, 32'h108, 4'h0, 32'h0); exp_read(1'b0, 32'h108);
        cyc(); iReq = 1'b0;
        cyc(); cyc();

        // Held conflict after reset: I, D, I, D
        reset = 1'b1;
        cyc(); reset = 1'b0;
        iReq = 1'b1; dReq = 1'b1; iAddr = 32'h400; dAddr = 32'h800; dWMask = 4'h0;
        for (int k = 0; k < 2; k++) begin
            exp_grant(1'b0, 32'h400, 4'h0, 32'h0); exp_read(1'b0, 32'h400);
            exp_grant(1'b1, 32'h800, 4'h0, 32'h0); exp_read(1'b1, 32'h800);
        end
        repeat (7) cyc();
        iReq = 1'b0; dReq = 1'b0;
        cyc(); cyc();
        chk("cnt_four_conflicts", conflictCount, 4);
        chk("cnt_s_saturated", conflictCount_s, 3);

        // Data request pulsed only during WAIT_I is never serviced
        iReq = 1'b1; iAddr = 32'h10C;
        exp_grant(1'b0, 32'h10C, 4'h0, 32'h0); exp_read(1'b0, 32'h10C);
        cyc(); iReq = 1'b0; dReq = 1'b1; dAddr = 32'h300;
        cyc(); dReq = 1'b0;
        cyc(); cyc();

        // Conflict with a D write after an I grant: D wins, then I next cycle
        iReq = 1'b1; iAddr = 32'h110;
        dReq = 1'b1; dAddr = 32'h208; dWMask = 4'hC; dWData = 32'h1234_0000;
        exp_grant(1'b1, 32'h208, 4'hC, 32'h1234_0000);
        exp_grant(1'b0, 32'h110, 4'h0, 32'h0); exp_read(1'b0, 32'h110);
        cyc(); dReq = 1'b0; dWMask = 4'h0;
        cyc(); iReq = 1'b0;
        cyc(); cyc();
        chk("cnt_five_conflicts", conflictCount, 5);
        chk("cnt_s_still_saturated", conflictCount_s, 3);

        // Reset during WAIT_I drops the read; arbiter is IDLE right after
        iReq = 1'b1; iAddr = 32'h114;
        exp_grant(1'b0, 32'h114, 4'h0, 32'h0);
        cyc(); iReq = 1'b0; reset = 1'b1;
        cyc(); reset = 1'b0;
        chk("cnt_after_wait_reset", conflictCount, 0);
        dReq = 1'b1; dAddr = 32'h20C; dWMask = 4'h0;
        exp_grant(1'b1, 32'h20C, 4'h0, 32'h0); exp_read(1'b1, 32'h20C);
        cyc(); dReq = 1'b0;
        cyc(); cyc(); cyc();

        chk("grant_queue_drained", gq.size(), 0);
        chk("read_queue_drained", rq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL expose the following parameters (name, default, meaning):
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- CNT_W, 16, conflict counter width.
REQ-002 The block SHALL expose the following ports (name, direction, width, meaning):
- clk, in, 1, sole clock.
- reset, in, 1, synchronous active-high reset.
- iReq, in, 1, instruction-fetch read request.
- iAddr, in, ADDR_W, fetch byte address.
- iReady, out, 1, fetch request accepted this cycle.
- iRValid, out, 1, fetch read data valid.
- iRData, out, DATA_W, fetch read data.
- dReq, in, 1, data request.
- dAddr, in, ADDR_W, data byte address.
- dWMask, in, 4, byte write mask; 0 means read.
- dWData, in, DATA_W, store data, already lane-aligned.
- dReady, out, 1, data request accepted this cycle.
- dRValid, out, 1, load data valid.
- dRData, out, DATA_W, load data.
- ramAddr, out, ADDR_W, shared RAM address.
- ramRStrb, out, 1, RAM read strobe.
- ramWData, out, DATA_W, RAM write data.
- ramWMask, out, 4, RAM byte write enables.
- ramRData, in, DATA_W, RAM read data, valid one cycle after ramRStrb.
- conflictCount, out, CNT_W, number of cycles in which both requesters were pending at grant time.
REQ-003 The block SHALL use one clock, clk, with reset synchronous and active-high on port reset.

Function
REQ-004 The block SHALL implement three states: IDLE, WAIT_I and WAIT_D.
REQ-005 In IDLE, the block SHALL grant at most one requester per cycle; grant SHALL be combinational from iReq, dReq and lastGrant, and reflected on iReady or dReady.
REQ-006 Only iReq pending -> grant I; only dReq pending -> grant D; both pending -> grant the port opposite lastGrant (round-robin).
REQ-007 lastGrant SHALL update on every grant.
REQ-008 In the grant cycle, ramAddr SHALL equal the granted address.
REQ-009 For a granted read, ramRStrb SHALL be 1 and ramWMask SHALL be 0.
REQ-010 For a granted D write, ramWMask SHALL equal dWMask, ramWData SHALL equal dWData, and ramRStrb SHALL be 0.
REQ-011 With no grant, ramRStrb=0, ramWMask=0, and ramAddr/ramWData are don't-care.
REQ-012 Granted I read -> WAIT_I; granted D read -> WAIT_D; granted D write -> stay in IDLE, so back-to-back grants are possible next cycle.
REQ-013 In WAIT_I, the block SHALL assert iRValid=1 and iRData=ramRData; in WAIT_D, dRValid=1 and dRData=ramRData; each state lasts exactly one cycle, then returns to IDLE.
REQ-014 In WAIT_I and WAIT_D, iReady=dReady=0, ramRStrb=0 and ramWMask=0; read latency SHALL be exactly 1 cycle from grant to rvalid.
REQ-015 Requesters SHALL hold req, addr, mask and data stable until ready; a req deasserted before grant is simply not serviced; the block SHALL NOT latch requests.
REQ-016 rvalid SHALL be a single-cycle pulse with no back-pressure; iRData and dRData SHALL be don't-care when the corresponding valid is 0.
REQ-017 conflictCount SHALL increment by 1 on each IDLE cycle with iReq=dReq=1, and saturate at 2^CNT_W-1 (no wrap).
REQ-018 A request arriving during WAIT_x SHALL be considered in the next IDLE cycle under the normal round-robin rule.

Reset
REQ-019 While reset=1 at a clk edge, the block SHALL set state=IDLE, lastGrant=D (so I wins the first conflict) and conflictCount=0.
REQ-020 During the reset cycle, iReady, dReady, ramRStrb and ramWMask SHALL be forced to 0, and iRValid and dRValid SHALL be 0.
REQ-021 Reset asserted in WAIT_x SHALL drop the in-flight read: no rvalid in the following cycle.

Structure
REQ-022 Package mem_arb_pkg SHALL hold the state encoding (IDLE/WAIT_I/WAIT_D), the grant encoding (GRANT_I/GRANT_D) and the ADDR_W/DATA_W defaults.
REQ-023 Round-robin selection SHALL live in one sub-module, mem_arb_rr (inputs iReq, dReq, lastGrant; outputs grantI, grantD); everything else SHALL stay in mem_arbiter.

Verification
REQ-024 After reset, iReq=1 with iAddr=0x100 and ramRData=0xDEADBEEF in the next cycle -> iReady=1, ramRStrb=1, ramAddr=0x100; next cycle iRValid=1, iRData=0xDEADBEEF.
REQ-025 After reset, iReq=dReq=1 held -> grant order I, D(read), I, D; one wait cycle per read; conflictCount=4.
REQ-026 dReq=1 with dWMask=0x3, dAddr=0x204, dWData=0x0000ABCD -> dReady=1, ramWMask=0x3, ramWData=0x0000ABCD in the same cycle; no dRValid; a new grant is possible the next cycle.
REQ-027 I read granted, reset=1 in the WAIT_I cycle -> iRValid=0 the following cycle, state=IDLE, conflictCount=0.
REQ-028 With CNT_W=2 and 5 conflict cycles -> conflictCount stays at 3.
REQ-029 dReq pulsed 1 during WAIT_I and dropped before IDLE -> no dReady and no RAM access.
